dmem_wbuf_controller: RTL and testbench

DMEM_WBUF_CONTROLLER -- requirements
Module: dmem_wbuf_controller

---
 rtl/dmem_wbuf_controller_if.sv | 38 +++
 rtl/dmem_wbuf_controller.sv | 170 +++++++++++++++++
 tb/tb_dmem_wbuf_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_wbuf_controller_if.sv
// CPU-side and cache-side signal bundle for the data-memory write-buffer
// controller. The controller uses the slave view; the CPU/cache environment
// uses the master view.
interface dmem_wbuf_controller_if #(
  parameter int ADDR_WIDTH = 25
);
  // CPU request / response
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_rdata_valid;
  logic                  stall_m;
  logic                  stall_w;
  // Cache request / response
  logic [ADDR_WIDTH-1:0] cache_req_addr;
  logic [31:0]           cache_req_data;
  logic                  cache_req_wr;
  logic                  cache_req_valid;
  logic                  cache_req_ready;
  logic [31:0]           cache_rsp_data;
  logic                  cache_rsp_valid;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rdata_valid, stall_m, stall_w,
    output cache_req_addr, cache_req_data, cache_req_wr, cache_req_valid,
    input  cache_req_ready, cache_rsp_data, cache_rsp_valid
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rdata_valid, stall_m, stall_w,
    input  cache_req_addr, cache_req_data, cache_req_wr, cache_req_valid,
    output cache_req_ready, cache_rsp_data, cache_rsp_valid
  );
endinterface

// File: rtl/dmem_wbuf_controller.sv
// Data-memory store buffer: stores are queued in a small FIFO and drained to
// the cache as writes when the cache is otherwise idle. Loads forward from the
// youngest matching buffered store, or bypass the buffer with a cache read
// when no buffered store matches.
module dmem_wbuf_controller #(
  parameter int ADDR_WIDTH = 25,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_wbuf_controller_if.slave  bus,
  output logic                   buf_empty,
  output logic [$clog2(DEPTH):0] buf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [31:0]           data_mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic                  is_load_s, is_store_s, full_s;
  logic                  hit_s;
  logic [31:0]           hit_data_s;
  logic [PW-1:0]         scan_idx_s;
  logic                  push_s, pop_s, rsp_take_s;
  logic                  stall_m_s, stall_w_s, req_valid_s, req_wr_s;
  logic [ADDR_WIDTH-1:0] req_addr_s;
  logic [31:0]           req_data_s;
  logic                  unused_addr_bits_s;

  assign word_addr_s        = bus.cpu_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits_s = ^{bus.cpu_addr[31:ADDR_WIDTH+2], bus.cpu_addr[1:0]};
  // A simultaneous load and store is served as the load alone.
  assign is_load_s          = bus.cpu_rd;
  assign is_store_s         = bus.cpu_wr & ~bus.cpu_rd;
  assign full_s             = (count_q == CW'(DEPTH));

  // Scan buffered stores oldest to youngest so the youngest match wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 32'h0000_0000;
    scan_idx_s = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem_q[scan_idx_s] == word_addr_s)) begin
        hit_s      = 1'b1;
        hit_data_s = data_mem_q[scan_idx_s];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Next-state, FIFO bookkeeping and cache request selection.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    rsp_take_s    = 1'b0;
    stall_m_s     = 1'b0;
    stall_w_s     = 1'b0;
    req_valid_s   = 1'b0;
    req_wr_s      = 1'b1;
    req_addr_s    = addr_mem_q[rd_ptr_q];
    req_data_s    = data_mem_q[rd_ptr_q];
    case (state_q)
      IDLE: begin
        if (is_load_s) begin
          // Loads take priority over draining the buffer.
          if (hit_s) begin
            rdata_valid_d = 1'b1;
            rdata_d       = hit_data_s;
          end else if (bus.cache_req_ready) begin
            req_valid_s = 1'b1;
            req_addr_s  = word_addr_s;
            state_d     = LOAD_WAIT;
          end else begin
            stall_m_s   = 1'b1;
          end
        end else if (count_q != CW'(0)) begin
          req_valid_s = 1'b1;
          req_wr_s    = 1'b0;
          pop_s       = bus.cache_req_ready;
        end else begin
          req_valid_s = 1'b0;
        end
      end
      LOAD_WAIT: begin
        stall_m_s = is_load_s;
        stall_w_s = ~bus.cache_rsp_valid;
        if (bus.cache_rsp_valid) begin
          rsp_take_s = 1'b1;
          state_d    = IDLE;
        end else begin
          rsp_take_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A full buffer refuses the store even if the head drains this cycle.
    if (is_store_s) begin
      if (full_s) begin
        stall_m_s = 1'b1;
      end else begin
        push_s    = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_s);
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rdata_q       <= 32'h0000_0000;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Store-buffer storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      addr_mem_q[wr_ptr_q] <= word_addr_s;
      data_mem_q[wr_ptr_q] <= bus.cpu_wdata;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign bus.stall_m         = reset & stall_m_s;
  assign bus.stall_w         = reset & stall_w_s;
  assign bus.cache_req_valid = reset & req_valid_s;
  assign bus.cache_req_wr    = ~reset | req_wr_s;
  assign bus.cache_req_addr  = req_addr_s;
  assign bus.cache_req_data  = req_data_s;
  // Cache read data passes straight through in the response cycle.
  assign bus.cpu_rdata       = (reset & rsp_take_s) ? bus.cache_rsp_data : rdata_q;
  assign bus.cpu_rdata_valid = (reset & rsp_take_s) | rdata_valid_q;
  assign buf_empty           = ~reset | (count_q == CW'(0));
  assign buf_count           = count_q;
endmodule

// File: tb/tb_dmem_wbuf_controller.sv
// Bench for dmem_wbuf_controller: a queue-based model of the store buffer is
// checked against the DUT on every cycle, alongside directed scenarios with
// literal expectations.
module tb_dmem_wbuf_controller;
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       buf_empty;
  logic [2:0] buf_count;
  int         n_cmp = 0;
  int         n_bad = 0;

  dmem_wbuf_controller_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_wbuf_controller #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .buf_empty (buf_empty),
    .buf_count (buf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ent_t          sq[$];
  bit            pend = 1'b0;
  bit            fv = 1'b0;
  logic [31:0]   fd = 32'h0;
  bit            d_rst, d_pop, d_push, d_pset, d_pclr, d_fwd, hit;
  logic [31:0]   d_fd, hd, e_d, e_rd;
  ent_t          d_ent;
  logic [AW-1:0] wa, e_a;
  bit            e_sm, e_sw, e_v, e_wr, e_rv;
  int            n;

  always begin : model_cmp
    @(negedge clk);
    wa = bus.cpu_addr[AW+1:2];
    n = sq.size();
    {d_rst, d_pop, d_push, d_pset, d_pclr, d_fwd, hit} = 7'b0;
    {e_sm, e_sw, e_v} = 3'b0;
    e_wr = 1'b1; e_a = '0; e_d = 32'h0; d_fd = 32'h0; hd = 32'h0; d_ent = '0;
    e_rv = fv; e_rd = fd;
    if (!reset) begin
      d_rst = 1'b1;
    end else begin
      if (!pend) begin
        if (bus.cpu_rd) begin
          for (int i = n - 1; i >= 0; i--)
            if (!hit && sq[i].a == wa) begin hit = 1'b1; hd = sq[i].d; end
          if (hit) begin d_fwd = 1'b1; d_fd = hd; end
          else if (bus.cache_req_ready) begin e_v = 1'b1; e_a = wa; d_pset = 1'b1; end
          else e_sm = 1'b1;
        end else if (n > 0) begin
          e_v = 1'b1; e_wr = 1'b0; e_a = sq[0].a; e_d = sq[0].d;
          d_pop = bus.cache_req_ready;
        end
      end else begin
        e_sw = !bus.cache_rsp_valid;
        e_sm = bus.cpu_rd;
        if (bus.cache_rsp_valid) begin e_rv = 1'b1; e_rd = bus.cache_rsp_data; d_pclr = 1'b1; end
      end
      if (bus.cpu_wr && !bus.cpu_rd) begin
        if (n == DEPTH) e_sm = 1'b1;
        else begin d_push = 1'b1; d_ent = '{a: wa, d: bus.cpu_wdata}; end
      end
    end
    chk("m_stall_m", {31'b0, bus.stall_m}, {31'b0, e_sm});
    chk("m_stall_w", {31'b0, bus.stall_w}, {31'b0, e_sw});
    chk("m_req_valid", {31'b0, bus.cache_req_valid}, {31'b0, e_v});
    chk("m_req_wr", {31'b0, bus.cache_req_wr}, {31'b0, e_wr});
    if (e_v) chk("m_req_addr", {7'b0, bus.cache_req_addr}, {7'b0, e_a});
    if (e_v && !e_wr) chk("m_req_data", bus.cache_req_data, e_d);
    chk("m_rdata_valid", {31'b0, bus.cpu_rdata_valid}, {31'b0, e_rv});
    if (e_rv) chk("m_rdata", bus.cpu_rdata, e_rd);
    chk("m_buf_count", {29'b0, buf_count}, n);
    chk("m_buf_empty", {31'b0, buf_empty}, {31'b0, (!reset || n == 0)});
    @(posedge clk);
    if (d_rst) begin
      sq.delete(); pend = 1'b0; fv = 1'b0; fd = 32'h0;
    end else begin
      if (d_pop) void'(sq.pop_front());
      if (d_push) sq.push_back(d_ent);
      if (d_pset) pend = 1'b1;
      if (d_pclr) pend = 1'b0;
      fv = d_fwd;
      if (d_fwd) fd = d_fd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit rdy, input bit rspv, input logic [31:0] rspd);
    @(posedge clk);
    #1;
    reset = rst;
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = wd;
    bus.cache_req_ready = rdy; bus.cache_rsp_valid = rspv; bus.cache_rsp_data = rspd;
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input bit rdy);
    cyc(1'b1, 1'b0, 1'b1, a, d, rdy, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input bit rdy);
    cyc(1'b1, 1'b1, 1'b0, a, 32'h0, rdy, 1'b0, 32'h0);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0, 32'h0);
  endtask

  logic [31:0] exp_a [4] = '{32'h401, 32'h402, 32'h403, 32'h404};
  logic [31:0] exp_d [4] = '{32'h2, 32'h3, 32'h4, 32'h5};

  initial begin
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.cache_req_ready = 1'b0; bus.cache_rsp_valid = 1'b0; bus.cache_rsp_data = 32'h0;

    // Reset, with busy inputs on the second cycle.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 32'h9, 1'b0, 1'b1, 32'h7);
    chk("rst_count", {29'b0, buf_count}, 32'h0);
    chk("rst_empty", {31'b0, buf_empty}, 32'h1);
    chk("rst_stall_m", {31'b0, bus.stall_m}, 32'h0);
    chk("rst_req_valid", {31'b0, bus.cache_req_valid}, 32'h0);
    chk("rst_req_wr", {31'b0, bus.cache_req_wr}, 32'h1);
    chk("rst_rdata_valid", {31'b0, bus.cpu_rdata_valid}, 32'h0);

    // Fill to DEPTH, fifth store stalls; pop and store in the same cycle.
    for (int i = 0; i < 4; i++) st(32'h1000 + 32'(4 * i), 32'(i + 1), 1'b0);
    st(32'h1010, 32'h5, 1'b0);
    chk("full_count", {29'b0, buf_count}, 32'h4);
    chk("full_stall", {31'b0, bus.stall_m}, 32'h1);
    st(32'h1010, 32'h5, 1'b1);
    chk("pop_full_stall", {31'b0, bus.stall_m}, 32'h1);
    chk("pop_addr", {7'b0, bus.cache_req_addr}, 32'h400);
    chk("pop_data", bus.cache_req_data, 32'h1);
    st(32'h1010, 32'h5, 1'b0);
    chk("after_pop_count", {29'b0, buf_count}, 32'h3);
    chk("after_pop_stall", {31'b0, bus.stall_m}, 32'h0);
    idle(1'b0);
    chk("refill_count", {29'b0, buf_count}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("drain_addr", {7'b0, bus.cache_req_addr}, exp_a[i]);
      chk("drain_data", bus.cache_req_data, exp_d[i]);
    end
    idle(1'b0);
    chk("drained_empty", {31'b0, buf_empty}, 32'h1);

    // Forward from the youngest of two matching stores.
    st(32'h100, 32'h11, 1'b0);
    st(32'h100, 32'h22, 1'b0);
    ld(32'h100, 1'b0);
    chk("fwd_stall", {31'b0, bus.stall_m}, 32'h0);
    chk("fwd_no_req", {31'b0, bus.cache_req_valid}, 32'h0);
    idle(1'b0);
    chk("fwd_valid", {31'b0, bus.cpu_rdata_valid}, 32'h1);
    chk("fwd_data", bus.cpu_rdata, 32'h22);
    idle(1'b0);
    chk("fwd_one_cycle", {31'b0, bus.cpu_rdata_valid}, 32'h0);
    // Load and store together: load only, store dropped.
    cyc(1'b1, 1'b1, 1'b1, 32'h100, 32'h99, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    chk("rdwr_data", bus.cpu_rdata, 32'h22);
    chk("rdwr_count", {29'b0, buf_count}, 32'h2);
    idle(1'b1);
    idle(1'b1);
    // Response while idle is ignored.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234);
    chk("idle_rsp_ignored", {31'b0, bus.cpu_rdata_valid}, 32'h0);

    // Missing load bypasses two buffered stores, then they drain in order.
    st(32'h300, 32'hA1, 1'b0);
    st(32'h304, 32'hB2, 1'b0);
    ld(32'h200, 1'b1);
    chk("miss_req_valid", {31'b0, bus.cache_req_valid}, 32'h1);
    chk("miss_req_wr", {31'b0, bus.cache_req_wr}, 32'h1);
    chk("miss_req_addr", {7'b0, bus.cache_req_addr}, 32'h80);
    idle(1'b1);
    chk("wait_stall_w", {31'b0, bus.stall_w}, 32'h1);
    chk("wait_no_drain", {31'b0, bus.cache_req_valid}, 32'h0);
    ld(32'h200, 1'b1);
    chk("wait_load_stall", {31'b0, bus.stall_m}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD);
    chk("rsp_valid", {31'b0, bus.cpu_rdata_valid}, 32'h1);
    chk("rsp_data", bus.cpu_rdata, 32'hDEAD);
    chk("rsp_stall_w", {31'b0, bus.stall_w}, 32'h0);
    idle(1'b1);
    chk("drain1_addr", {7'b0, bus.cache_req_addr}, 32'hC0);
    chk("drain1_data", bus.cache_req_data, 32'hA1);
    chk("drain1_wr", {31'b0, bus.cache_req_wr}, 32'h0);
    idle(1'b1);
    chk("drain2_addr", {7'b0, bus.cache_req_addr}, 32'hC1);
    chk("drain2_data", bus.cache_req_data, 32'hB2);
    idle(1'b0);

    // Reset while a load is outstanding with three stores buffered.
    st(32'h400, 32'h1, 1'b0);
    st(32'h404, 32'h2, 1'b0);
    st(32'h408, 32'h3, 1'b0);
    ld(32'h500, 1'b1);
    idle(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("mid_rst_stall_w", {31'b0, bus.stall_w}, 32'h0);
    chk("mid_rst_req_valid", {31'b0, bus.cache_req_valid}, 32'h0);
    chk("mid_rst_empty", {31'b0, buf_empty}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBEEF);
    chk("late_rsp_valid", {31'b0, bus.cpu_rdata_valid}, 32'h0);
    chk("late_rsp_count", {29'b0, buf_count}, 32'h0);
    idle(1'b0);

    // Pointer wrap: ten store/drain pairs.
    for (int i = 0; i < 10; i++) begin
      st(32'h2000 + 32'(8 * i), 32'h5A00 + 32'(i), 1'b0);
      idle(1'b1);
      chk("wrap_addr", {7'b0, bus.cache_req_addr}, 32'h800 + 32'(2 * i));
      chk("wrap_data", bus.cache_req_data, 32'h5A00 + 32'(i));
      chk("wrap_wr", {31'b0, bus.cache_req_wr}, 32'h0);
    end
    idle(1'b0);
    chk("wrap_empty", {31'b0, buf_empty}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
